// File: rtl/alu_seq_pkg.sv
// alu_sequencer shared types and constants.
// Overflow helper exists only when ALU_SEQ_OVF_EN is defined.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LDI_BIT = 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NEGA = 3'b010;
  localparam logic [2:0] OP_NEGB = 3'b011;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_SIGN  = 2;
  localparam int FLAG_OVF   = 3;

`ifdef ALU_SEQ_OVF_EN
  function automatic logic ovf_calc(
    input logic [2:0] op,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [3:0] r
  );
    logic v;
    v = 1'b0;
    unique case (1'b1)
      op == OP_ADD: v = (a[3] == b[3]) && (r[3] != a[3]);
      op == OP_SUB: v = (a[3] != b[3]) && (r[3] != a[3]);
      default:      v = 1'b0;
    endcase
    return v;
  endfunction
`endif

endpackage

// File: rtl/alu_seq_regfile4x4.sv
// Four 4-bit registers: one sync write, three comb reads.
// Reset wins over a same-cycle write.
module regfile4x4
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [1:0] wa,
  input  logic [3:0] wd,
  input  logic [1:0] rs_addr,
  input  logic [1:0] rt_addr,
  input  logic [1:0] dbg_addr,
  output logic [3:0] rs_data,
  output logic [3:0] rt_data,
  output logic [3:0] dbg_data
);

  logic [3:0] regs [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++)
        regs[i] <= 4'd0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rs_data  = regs[rs_addr];
  assign rt_data  = regs[rt_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Sequences LDI/ALU commands through an external ALU.
// Define ALU_SEQ_OVF_EN to add a registered signed-overflow flag.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_rs,
  input  logic [1:0] cmd_rt,
  output logic [3:0] alu_A,
  output logic [3:0] alu_B,
  output logic [1:0] alu_op,
  output logic       alu_L,
  input  logic [3:0] alu_R,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_sign,
  output logic       done,
  output logic [3:0] flags,
  input  logic [1:0] dbg_addr,
  output logic [3:0] dbg_data
);

  state_t     state;
  logic [3:0] op_q;
  logic [1:0] rd_q;
  logic [3:0] imm_q;
  logic [2:0] flags_q;
  logic [3:0] rs_data;
  logic [3:0] rt_data;
  logic       accept;
  logic       we;
  logic [3:0] wd;

  assign accept = cmd_valid & cmd_ready;
  assign we     = (state == EXEC);
  assign wd     = op_q[LDI_BIT] ? imm_q : alu_R;

  regfile4x4 u_rf (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .wa       (rd_q),
    .wd       (wd),
    .rs_addr  (cmd_rs),
    .rt_addr  (cmd_rt),
    .dbg_addr (dbg_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dbg_data (dbg_data)
  );

  // Operands are captured at accept so EXEC sees pre-write values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      alu_A     <= 4'd0;
      alu_B     <= 4'd0;
      alu_op    <= 2'd0;
      alu_L     <= 1'b0;
      op_q      <= 4'd0;
      rd_q      <= 2'd0;
      imm_q     <= 4'd0;
      flags_q   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= EXEC;
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            rd_q      <= cmd_rd;
            imm_q     <= {cmd_rs, cmd_rt};
            if (!cmd_op[LDI_BIT]) begin
              alu_A <= rs_data;
              alu_B <= rt_data;
              {alu_L, alu_op} <= cmd_op[2:0];
            end
          end
        end
        EXEC: begin
          state  <= DONE;
          done   <= 1'b1;
          alu_A  <= 4'd0;
          alu_B  <= 4'd0;
          alu_op <= 2'd0;
          alu_L  <= 1'b0;
          if (!op_q[LDI_BIT])
            flags_q <= {alu_sign, alu_carry, alu_zero};
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (reset)
      ovf_q <= 1'b0;
    else if (state == EXEC && !op_q[LDI_BIT])
      ovf_q <= ovf_calc(op_q[2:0], alu_A, alu_B, alu_R);
  end

  assign flags = {ovf_q, flags_q};
`else
  assign flags = {1'b0, flags_q};
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a cycle-level reference model.
// Expectations track ALU_SEQ_OVF_EN when it is defined.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_op = 4'd0;
  logic [1:0] cmd_rd = 2'd0;
  logic [1:0] cmd_rs = 2'd0;
  logic [1:0] cmd_rt = 2'd0;
  logic [1:0] dbg_addr = 2'd0;
  logic       cmd_ready;
  logic       done;
  logic       alu_L;
  logic       alu_zero;
  logic       alu_carry;
  logic       alu_sign;
  logic [3:0] alu_A;
  logic [3:0] alu_B;
  logic [3:0] alu_R;
  logic [3:0] flags;
  logic [3:0] dbg_data;
  logic [1:0] alu_op;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs    (cmd_rs),
    .cmd_rt    (cmd_rt),
    .alu_A     (alu_A),
    .alu_B     (alu_B),
    .alu_op    (alu_op),
    .alu_L     (alu_L),
    .alu_R     (alu_R),
    .alu_zero  (alu_zero),
    .alu_carry (alu_carry),
    .alu_sign  (alu_sign),
    .done      (done),
    .flags     (flags),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  function automatic int sx(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  // ALU behaviour: L=0 arithmetic, L=1 logic ops.
  function automatic void alu_ref(
    input  logic [2:0] op,
    input  int         a,
    input  int         b,
    output int         r,
    output bit         c,
    output bit         v
  );
    int s;
    s = 0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        s = a + b;
        c = (s > 15);
        v = (sx(a) + sx(b) > 7) || (sx(a) + sx(b) < -8);
      end
      3'd1: begin
        s = a - b;
        c = (a >= b);
        v = (sx(a) - sx(b) > 7) || (sx(a) - sx(b) < -8);
      end
      3'd2: begin s = -a; c = (a == 0); end
      3'd3: begin s = -b; c = (b == 0); end
      3'd4: s = a & b;
      3'd5: s = a | b;
      3'd6: s = a ^ b;
      default: s = ~a;
    endcase
    r = s & 15;
  endfunction

  always_comb begin : alu_stub
    int r;
    bit c;
    bit v;
    alu_ref({alu_L, alu_op}, int'(alu_A), int'(alu_B), r, c, v);
    alu_R     = 4'(r);
    alu_carry = c;
    alu_zero  = (r == 0);
    alu_sign  = (r >= 8);
  end

  logic [3:0] m_regs [4];
  logic [3:0] m_flags = 4'd0;
  logic [3:0] m_op = 4'd0;
  logic [1:0] m_rd = 2'd0;
  logic [1:0] m_rs = 2'd0;
  logic [1:0] m_rt = 2'd0;
  bit         m_busy = 1'b0;
  int         m_age = 0;
  bit         checking = 1'b0;

  // Reference: a command is busy for the cycle after accept (EXEC) and
  // the next one (DONE); the write lands on the edge entering DONE.
  always @(posedge clk) begin
    int r;
    bit c;
    bit v;
    if (reset) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
      m_flags  = 4'd0;
      m_busy   = 1'b0;
      m_age    = 0;
      checking = 1'b1;
    end else if (m_busy) begin
      if (m_age == 0) begin
        if (m_op[3]) begin
          m_regs[m_rd] = {m_rs, m_rt};
        end else begin
          alu_ref(m_op[2:0], int'(m_regs[m_rs]), int'(m_regs[m_rt]), r, c, v);
          m_regs[m_rd] = 4'(r);
`ifdef ALU_SEQ_OVF_EN
          m_flags = {v, (r >= 8), c, (r == 0)};
`else
          m_flags = {1'b0, (r >= 8), c, (r == 0)};
`endif
        end
        m_age = 1;
      end else begin
        m_busy = 1'b0;
      end
    end else if (cmd_valid) begin
      m_busy = 1'b1;
      m_age  = 0;
      m_op   = cmd_op;
      m_rd   = cmd_rd;
      m_rs   = cmd_rs;
      m_rt   = cmd_rt;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit ex;
    if (checking) begin
      ex = m_busy && m_age == 0 && !m_op[3];
      chk("cmd_ready", 8'(cmd_ready), 8'(!m_busy));
      chk("done", 8'(done), 8'(m_busy && m_age == 1));
      chk("alu_A", 8'(alu_A), ex ? 8'(m_regs[m_rs]) : 8'd0);
      chk("alu_B", 8'(alu_B), ex ? 8'(m_regs[m_rt]) : 8'd0);
      chk("alu_op", 8'(alu_op), ex ? 8'(m_op[1:0]) : 8'd0);
      chk("alu_L", 8'(alu_L), ex ? 8'(m_op[2]) : 8'd0);
      chk("flags", 8'(flags), 8'(m_flags));
      chk("dbg_data", 8'(dbg_data), 8'(m_regs[dbg_addr]));
    end
  end

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      ok = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 10 cycles");
    end
  endtask

  task automatic issue(
    input  logic [3:0] op,
    input  logic [1:0] rd,
    input  logic [1:0] rs,
    input  logic [1:0] rt,
    output logic [3:0] ea,
    output logic [3:0] eb
  );
    bit ok;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs    = rs;
    cmd_rt    = rt;
    cmd_valid = 1'b1;
    wait_accept(ok);
    ea = alu_A;
    eb = alu_B;
    chk("exec_done_low", 8'(done), 8'd0);
    @(posedge clk); #1;
    chk("done_pulse", 8'(done), 8'd1);
    @(posedge clk); #1;
    chk("done_clear", 8'(done), 8'd0);
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [3:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  initial begin
    logic [3:0] ea;
    logic [3:0] eb;
    logic [3:0] d;
    int  accepts;
    bit  ok;
    bit  seen_done;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_ready", 8'(cmd_ready), 8'd1);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_flags", 8'(flags), 8'd0);
    chk("rst_alu", 8'({alu_A, alu_B}), 8'd0);
    chk("rst_aluop", 8'({alu_L, alu_op}), 8'd0);
    for (int a = 0; a < 4; a++) begin
      rd_reg(2'(a), d);
      chk("rst_dbg", 8'(d), 8'd0);
    end

    issue(4'b1000, 2'd1, 2'b01, 2'b01, ea, eb);
    issue(4'b1000, 2'd2, 2'b00, 2'b11, ea, eb);
    rd_reg(2'd1, d); chk("ldi_r1", 8'(d), 8'h5);
    rd_reg(2'd2, d); chk("ldi_r2", 8'(d), 8'h3);
    chk("ldi_flags", 8'(flags), 8'h0);

    issue(4'b0000, 2'd3, 2'd1, 2'd2, ea, eb);
    chk("add_A", 8'(ea), 8'h5);
    chk("add_B", 8'(eb), 8'h3);
    rd_reg(2'd3, d); chk("add_r3", 8'(d), 8'h8);
`ifdef ALU_SEQ_OVF_EN
    chk("add_flags", 8'(flags), 8'b1100);
`else
    chk("add_flags", 8'(flags), 8'b0100);
`endif

    issue(4'b0001, 2'd0, 2'd2, 2'd2, ea, eb);
    rd_reg(2'd0, d); chk("sub_r0", 8'(d), 8'h0);
    chk("sub_flags", 8'(flags), 8'b0011);

    issue(4'b0010, 2'd1, 2'd1, 2'd0, ea, eb);
    rd_reg(2'd1, d); chk("nega_r1", 8'(d), 8'hB);
    chk("nega_flags", 8'(flags), 8'b0100);

    issue(4'b0110, 2'd2, 2'd3, 2'd1, ea, eb);
    rd_reg(2'd2, d); chk("xor_r2", 8'(d), 8'h3);

    cmd_op    = 4'b1000;
    cmd_rd    = 2'd0;
    cmd_rs    = 2'b10;
    cmd_rt    = 2'b10;
    cmd_valid = 1'b1;
    accepts   = 0;
    for (int i = 0; i < 9; i++) begin
      if (cmd_ready) accepts++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", 8'(accepts), 8'd3);
    repeat (2) @(posedge clk);
    #1;
    rd_reg(2'd0, d); chk("b2b_r0", 8'(d), 8'hA);

    cmd_op    = 4'b0000;
    cmd_rd    = 2'd2;
    cmd_rs    = 2'd1;
    cmd_rt    = 2'd1;
    cmd_valid = 1'b1;
    wait_accept(ok);
    reset     = 1'b1;
    seen_done = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 8'(seen_done), 8'd0);
    rd_reg(2'd2, d); chk("abort_r2", 8'(d), 8'h0);
    chk("abort_ready", 8'(cmd_ready), 8'd1);

    cmd_op    = 4'b1000;
    cmd_rd    = 2'd1;
    cmd_rs    = 2'b11;
    cmd_rt    = 2'b11;
    cmd_valid = 1'b1;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    chk("prio_ready", 8'(cmd_ready), 8'd1);
    @(posedge clk); #1;
    chk("prio_done", 8'(done), 8'd0);
    rd_reg(2'd1, d); chk("prio_r1", 8'(d), 8'h0);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameters: none; widths fixed (4-bit data, 4 registers, 2-bit register addresses).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  4  bit3 = LDI; bits[2:0] = {L, ALUOp[1:0]} for ALU commands.
REQ-007 cmd_rd / cmd_rs / cmd_rt  input  2 each  destination / first source / second source register; for LDI, immediate = {cmd_rs, cmd_rt}.
REQ-008 alu_A, alu_B  output  4 each  ALU operands.
REQ-009 alu_op  output  2  ALUOp to ALU; alu_L  output  1  logic/arithmetic select.
REQ-010 alu_R  input  4  ALU result; alu_zero, alu_carry, alu_sign  input  1 each  ALU flags.
REQ-011 done  output  1  one-cycle pulse, command retired.
REQ-012 flags  output  4  registered {ovf, sign, carry, zero}.
REQ-013 dbg_addr  input  2; dbg_data  output  4  combinational register read port.

Function
REQ-014 FSM states: IDLE, EXEC, DONE; IDLE->EXEC on cmd_valid & cmd_ready; EXEC->DONE unconditionally; DONE->IDLE unconditionally.
REQ-015 cmd_ready is high only in IDLE; command fields are latched on acceptance; inputs are ignored outside IDLE.
REQ-016 In EXEC for an ALU command: alu_A = reg[rs], alu_B = reg[rt], {alu_L, alu_op} = cmd_op[2:0], all driven from registered values.
REQ-017 Outside EXEC, and during EXEC of LDI: alu_A = alu_B = 0, alu_op = 00, alu_L = 0.
REQ-018 On the EXEC->DONE edge: ALU command writes reg[rd] <= alu_R and flags[2:0] <= {alu_sign, alu_carry, alu_zero}; LDI writes reg[rd] <= immediate and leaves flags unchanged.
REQ-019 done = 1 exactly in DONE; latency: accept at cycle N, write visible and done high at N+2; next accept no earlier than N+3.
REQ-020 rd equal to rs and/or rt is legal; operands come from pre-write values.
REQ-021 dbg_data = reg[dbg_addr]; reading rd in the write cycle returns the old value, the new value appears the following cycle.
REQ-022 Arithmetic is modulo 16; the sequencer never modifies alu_R.

Reset
REQ-023 reset forces state IDLE, all registers 0, flags 0, done 0, ALU outputs to the REQ-017 idle values, and cmd_ready 1 in the following cycle.
REQ-024 reset during EXEC or DONE aborts the command: no register or flag write, and no done pulse.
REQ-025 reset takes priority over a simultaneous command acceptance.

Configuration
REQ-026 Macro ALU_SEQ_OVF_EN is the only compile-time option.
REQ-027 With ALU_SEQ_OVF_EN: flags[3] <= signed overflow for ALU ops 000 (A+B: operands same sign, result differs) and 001 (A-B: operands differ in sign, result sign differs from A); flags[3] <= 0 for other ALU ops; LDI leaves it unchanged.
REQ-028 Without ALU_SEQ_OVF_EN: flags[3] is constant 0 and no overflow logic exists.

Structure
REQ-029 Shared package alu_seq_pkg holds the state enum (IDLE/EXEC/DONE), the LDI bit index, ALU opcode constants (ADD = 000, SUB = 001, NEGA = 010, NEGB = 011), and the flag bit positions.
REQ-030 One sub-module, regfile4x4: four 4-bit registers with one synchronous write port and three combinational read ports (rs, rt, dbg); it resets synchronously to 0.

Verification
REQ-031 After reset: cmd_ready = 1, done = 0, flags = 0000, dbg reads 0 for all addresses, ALU outputs 0.
REQ-032 LDI r1 = 5 (rs = 01, rt = 01), then LDI r2 = 3 -> dbg r1 = 0101, r2 = 0011; done pulses 2 cycles after each accept; flags unchanged.
REQ-033 ADD r3 = r1 + r2 (op 000) -> alu_A = 0101 and alu_B = 0011 in EXEC, r3 = 1000, flags = 1100 with OVF_EN (0100 without).
REQ-034 SUB r0 = r2 - r2 (op 001) -> r0 = 0000, flags zero = 1, carry = 1, sign = 0, ovf = 0.
REQ-035 cmd_valid held high continuously -> commands accepted only every 3 cycles, cmd_ready low in EXEC and DONE; reset asserted in EXEC -> rd unchanged, no done pulse.
